// File: rtl/insn_parcel_buffer_pkg.sv
// Shared processor types used by the fetch/decode instruction parcel buffer.
// Holds buffer sizing constants, the parcel entry record and the
// 16-bit parcel length-decode helper.
package insn_parcel_buffer_pkg;

    localparam int INSN_BUFFER_PARCEL_DEPTH  = 8;
    localparam int INSN_BUFFER_WRITE_PARCELS = 2;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] insn_t;

    // Occupancy count; one extra bit so a completely full buffer is representable.
    typedef logic [$clog2(INSN_BUFFER_PARCEL_DEPTH):0] insn_parcel_count_t;

    // One 16-bit instruction parcel as delivered by fetch.
    typedef struct packed {
        addr_t       pc;
        logic        fault;
        logic [15:0] insn;
    } InsnBufferEntry;

    // A parcel whose low two bits are not 2'b11 starts a 16-bit instruction.
    function automatic logic is_rvc_parcel(input logic [15:0] parcel);
        return parcel[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/insn_parcel_buffer_aligner.sv
// Combinational instruction aligner: looks at the head and next parcels and
// decides the instruction length, assembled bits, fault and validity.
// Compressed (16-bit) decode exists only when RAFI_RVC_EN is defined;
// otherwise every non-faulting instruction is two parcels wide.
module insn_parcel_aligner
    import insn_parcel_buffer_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  InsnBufferEntry   head,
    input  InsnBufferEntry   next,
    input  logic [CNT_W-1:0] count,
    output logic             valid,
    output logic [1:0]       length,
    output insn_t            insn,
    output logic             fault,
    output logic             compressed
);

    logic head_c;
    logic have_one;
    logic have_two;

    // pc fields are not needed to align; the top forwards head.pc itself.
    logic unused_pc;
    assign unused_pc = ^{head.pc, next.pc};

    // Length decode, then pick one or two parcels. A faulting head is emitted
    // alone so decode sees the fault without waiting on a parcel that may
    // never arrive.
    always_comb begin
`ifdef RAFI_RVC_EN
        head_c = is_rvc_parcel(head.insn);
`else
        head_c = 1'b0;
`endif
        have_one   = count != '0;
        have_two   = count >= CNT_W'(2);
        compressed = head_c;
        if (head.fault || head_c) begin
            length = 2'd1;
            insn   = {16'h0, head.insn};
            valid  = have_one;
            fault  = head.fault;
        end else begin
            length = 2'd2;
            insn   = {next.insn, head.insn};
            valid  = have_two;
            fault  = next.fault;
        end
    end

endmodule

// File: rtl/insn_parcel_buffer.sv
// Instruction parcel buffer between fetch and decode.
// Circular buffer of 16-bit parcels; accepts up to WRITE_PARCELS parcels per
// cycle and presents one aligned 16- or 32-bit instruction per cycle.
// Optional feature macro: RAFI_RVC_EN enables 16-bit (compressed) decode.
module insn_parcel_buffer
    import insn_parcel_buffer_pkg::*;
#(
    parameter int DEPTH         = INSN_BUFFER_PARCEL_DEPTH,
    parameter int WRITE_PARCELS = INSN_BUFFER_WRITE_PARCELS
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 flush,
    input  logic                                 in_valid,
    input  logic [$clog2(WRITE_PARCELS):0]       in_count,
    input  InsnBufferEntry [WRITE_PARCELS-1:0]   in_entry,
    output logic                                 in_ready,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output addr_t                                out_pc,
    output insn_t                                out_insn,
    output logic                                 out_compressed,
    output logic                                 out_fault,
    output logic [$clog2(DEPTH):0]               count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    InsnBufferEntry   mem_q [DEPTH];
    InsnBufferEntry   mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    InsnBufferEntry   head_ent;
    InsnBufferEntry   next_ent;
    logic [1:0]       pop_len;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] push_n;
    logic [CNT_W-1:0] pop_n;

    // Head and the parcel after it (natural pointer wrap) feed the aligner.
    always_comb begin
        head_ent = mem_q[head_q];
        next_ent = mem_q[head_q + PTR_W'(1)];
    end

    insn_parcel_aligner #(
        .CNT_W (CNT_W)
    ) u_aligner (
        .head       (head_ent),
        .next       (next_ent),
        .count      (count_q),
        .valid      (out_valid),
        .length     (pop_len),
        .insn       (out_insn),
        .fault      (out_fault),
        .compressed (out_compressed)
    );

    assign out_pc = head_ent.pc;
    assign count  = count_q;

    // Ready looks only at registered occupancy so there is no path from
    // out_ready back to in_ready; a same-cycle pop is not credited.
    always_comb begin
        in_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(WRITE_PARCELS);
        push     = in_valid && in_ready;
        pop      = out_valid && out_ready;
        push_n   = push ? CNT_W'(in_count) : '0;
        pop_n    = pop  ? CNT_W'(pop_len)  : '0;
    end

    // Next state: flush wins and drops any push; otherwise write the pushed
    // slots at tail onward, advance head by the consumed length.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                for (int i = 0; i < WRITE_PARCELS; i++) begin
                    if (i < int'(in_count)) begin
                        mem_d[tail_q + PTR_W'(i)] = in_entry[i];
                    end
                end
                tail_d = tail_q + PTR_W'(in_count);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(pop_len);
            end
            count_d = count_q + push_n - pop_n;
        end
    end

    // Pointers and occupancy reset asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Parcel storage is not reset; occupancy alone says what is meaningful.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
